// File: rtl/oclib_pkg.sv
// oclib_pkg: shared types and constants for the BC FIFO adapter slice.
// Provides bc_fifo_status_s (lane occupancy + almost-full), BcFifoMaxDepth,
// the count width that covers any legal depth, a maxInt helper, and the
// OC_STATIC_ERROR elaboration-failure macro.
`ifndef OC_STATIC_ERROR
`define OC_STATIC_ERROR(msg) $error(msg)
`endif

package oclib_pkg;

    localparam int BcFifoMaxDepth = 256;
    localparam int BcCountWidth = $clog2(BcFifoMaxDepth + 1);

    typedef struct packed {
        logic [BcCountWidth-1:0] count;
        logic                    almostFull;
    } bc_fifo_status_s;

    function automatic int maxInt(input int a, input int b);
        return a > b ? a : b;
    endfunction

endpackage

// File: rtl/oclib_bc_fifo_lane.sv
// oclib_bc_fifo_lane: one direction of a BC ready/valid first-word-fall-through FIFO.
// Ports: clock, reset (async active-low); inData/inValid/inReady (push side);
// outData/outValid/outReady (pop side); flush (sync, drops all beats);
// count (occupancy), almostFull (count >= AlmostFull).
// Optional macro OC_BC_BIDI_FIFO_STATS_EN adds beats (pops) and stalls
// (outValid & !outReady cycles), both saturating and cleared by flush.
module oclib_bc_fifo_lane
    import oclib_pkg::*;
#(
    parameter int Width      = 8,
    parameter int Depth      = 4,
    parameter int AlmostFull = Depth - 1,
    parameter int CountWidth = $clog2(Depth + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [Width-1:0]      inData,
    input  logic                  inValid,
    output logic                  inReady,
    output logic [Width-1:0]      outData,
    output logic                  outValid,
    input  logic                  outReady,
    input  logic                  flush,
`ifdef OC_BC_BIDI_FIFO_STATS_EN
    output logic [31:0]           beats,
    output logic [31:0]           stalls,
`endif
    output logic [CountWidth-1:0] count,
    output logic                  almostFull
);

    localparam int PtrWidth = $clog2(Depth);

    if (Depth < 2 || Depth > BcFifoMaxDepth) begin : gDepthCheck
        `OC_STATIC_ERROR("oclib_bc_fifo_lane: Depth must be 2..256");
    end
    if (AlmostFull > Depth) begin : gAlmostFullCheck
        `OC_STATIC_ERROR("oclib_bc_fifo_lane: AlmostFull exceeds Depth");
    end
    if (CountWidth < $clog2(Depth + 1)) begin : gCountWidthCheck
        `OC_STATIC_ERROR("oclib_bc_fifo_lane: CountWidth too narrow for Depth");
    end

    logic [Width-1:0]    mem [Depth];
    logic [PtrWidth-1:0] wrPtr, rdPtr;
    logic                inReadyQ;
    logic                push, pop;
    bc_fifo_status_s     nxt;

    function automatic logic [PtrWidth-1:0] bump(input logic [PtrWidth-1:0] p);
        return p == PtrWidth'(Depth - 1) ? '0 : p + PtrWidth'(1);
    endfunction

    // Flush masks the registered ready so nothing is accepted in the flush cycle.
    assign inReady = inReadyQ & ~flush;
    assign push    = inValid & inReady;
    assign pop     = outValid & outReady;
    assign outData = mem[rdPtr];

    always_comb begin
        nxt.count      = flush ? '0 : BcCountWidth'(count) + BcCountWidth'(push) - BcCountWidth'(pop);
        nxt.almostFull = nxt.count >= BcCountWidth'(AlmostFull);
    end

    always_ff @(posedge clock) begin
        if (push) mem[wrPtr] <= inData;
    end

    // Ready, valid and almost-full all come from the next-state count so they
    // are registered yet never lag the occupancy.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wrPtr      <= '0;
            rdPtr      <= '0;
            count      <= '0;
            inReadyQ   <= 1'b0;
            outValid   <= 1'b0;
            almostFull <= 1'b0;
        end else begin
            wrPtr      <= flush ? '0 : push ? bump(wrPtr) : wrPtr;
            rdPtr      <= flush ? '0 : pop ? bump(rdPtr) : rdPtr;
            count      <= CountWidth'(nxt.count);
            inReadyQ   <= nxt.count < BcCountWidth'(Depth);
            outValid   <= nxt.count != '0;
            almostFull <= nxt.almostFull;
        end
    end

`ifdef OC_BC_BIDI_FIFO_STATS_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            beats  <= '0;
            stalls <= '0;
        end else begin
            beats  <= flush ? '0 : (pop && beats != '1) ? beats + 32'd1 : beats;
            stalls <= flush ? '0 : (outValid && !outReady && stalls != '1) ? stalls + 32'd1 : stalls;
        end
    end
`endif

endmodule

// File: rtl/oclib_bc_bidi_fifo_adapter.sv
// oclib_bc_bidi_fifo_adapter: bidirectional BC ready/valid FIFO buffer between endpoints A and B.
// Ports: clock, reset (async active-low);
// A->B lane: aInData/aInValid/aOutReady in, bOutData/bOutValid/bInReady out,
//            abFlush, abCount, abAlmostFull;
// B->A lane: bInData/bInValid/bOutReady in, aOutData/aOutValid/aInReady out,
//            baFlush, baCount, baAlmostFull.
// Optional macro OC_BC_BIDI_FIFO_STATS_EN adds abBeats, baBeats, abStalls, baStalls.
module oclib_bc_bidi_fifo_adapter
    import oclib_pkg::*;
#(
    parameter int Width        = 8,
    parameter int DepthAB      = 4,
    parameter int DepthBA      = 4,
    parameter int AlmostFullAB = DepthAB - 1,
    parameter int AlmostFullBA = DepthBA - 1,
    parameter int CountWidth   = $clog2(maxInt(DepthAB, DepthBA) + 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [Width-1:0]      aInData,
    input  logic                  aInValid,
    output logic                  aOutReady,
    output logic [Width-1:0]      bOutData,
    output logic                  bOutValid,
    input  logic                  bInReady,
    input  logic [Width-1:0]      bInData,
    input  logic                  bInValid,
    output logic                  bOutReady,
    output logic [Width-1:0]      aOutData,
    output logic                  aOutValid,
    input  logic                  aInReady,
    input  logic                  abFlush,
    input  logic                  baFlush,
`ifdef OC_BC_BIDI_FIFO_STATS_EN
    output logic [31:0]           abBeats,
    output logic [31:0]           baBeats,
    output logic [31:0]           abStalls,
    output logic [31:0]           baStalls,
`endif
    output logic [CountWidth-1:0] abCount,
    output logic [CountWidth-1:0] baCount,
    output logic                  abAlmostFull,
    output logic                  baAlmostFull
);

    if (DepthAB < 2 || DepthBA < 2 || AlmostFullAB > DepthAB || AlmostFullBA > DepthBA) begin : gParamCheck
        `OC_STATIC_ERROR("oclib_bc_bidi_fifo_adapter: illegal depth/almost-full combination");
    end

    oclib_bc_fifo_lane #(
        .Width(Width), .Depth(DepthAB), .AlmostFull(AlmostFullAB), .CountWidth(CountWidth)
    ) uLaneAB (
        .clock(clock), .reset(reset),
        .inData(aInData), .inValid(aInValid), .inReady(aOutReady),
        .outData(bOutData), .outValid(bOutValid), .outReady(bInReady),
        .flush(abFlush),
`ifdef OC_BC_BIDI_FIFO_STATS_EN
        .beats(abBeats), .stalls(abStalls),
`endif
        .count(abCount), .almostFull(abAlmostFull)
    );

    oclib_bc_fifo_lane #(
        .Width(Width), .Depth(DepthBA), .AlmostFull(AlmostFullBA), .CountWidth(CountWidth)
    ) uLaneBA (
        .clock(clock), .reset(reset),
        .inData(bInData), .inValid(bInValid), .inReady(bOutReady),
        .outData(aOutData), .outValid(aOutValid), .outReady(aInReady),
        .flush(baFlush),
`ifdef OC_BC_BIDI_FIFO_STATS_EN
        .beats(baBeats), .stalls(baStalls),
`endif
        .count(baCount), .almostFull(baAlmostFull)
    );

endmodule

// File: tb/tb_oclib_bc_bidi_fifo_adapter.sv
// tb_oclib_bc_bidi_fifo_adapter: self-checking bench for the bidirectional BC FIFO adapter.
module tb_oclib_bc_bidi_fifo_adapter;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [W-1:0] aInData = '0, bInData = '0, bOutData, aOutData;
    logic         aInValid = 1'b0, bInReady = 1'b0, bInValid = 1'b0, aInReady = 1'b0;
    logic         abFlush = 1'b0, baFlush = 1'b0;
    logic         aOutReady, bOutValid, bOutReady, aOutValid, abAlmostFull, baAlmostFull;
    logic [2:0]   abCount, baCount;
`ifdef OC_BC_BIDI_FIFO_STATS_EN
    logic [31:0]  abBeats, baBeats, abStalls, baStalls;
`endif

    int nVec = 0;
    int nFail = 0;

    always #5 clock = ~clock;

    oclib_bc_bidi_fifo_adapter #(.Width(W), .DepthAB(4), .DepthBA(3)) dut (
        .clock(clock), .reset(reset),
        .aInData(aInData), .aInValid(aInValid), .aOutReady(aOutReady),
        .bOutData(bOutData), .bOutValid(bOutValid), .bInReady(bInReady),
        .bInData(bInData), .bInValid(bInValid), .bOutReady(bOutReady),
        .aOutData(aOutData), .aOutValid(aOutValid), .aInReady(aInReady),
        .abFlush(abFlush), .baFlush(baFlush),
`ifdef OC_BC_BIDI_FIFO_STATS_EN
        .abBeats(abBeats), .baBeats(baBeats), .abStalls(abStalls), .baStalls(baStalls),
`endif
        .abCount(abCount), .baCount(baCount),
        .abAlmostFull(abAlmostFull), .baAlmostFull(baAlmostFull)
    );

    typedef struct {
        logic         aV;
        logic [W-1:0] aD;
        logic         bR;
        logic         fl;
        logic         eRdy;
        logic         eVal;
        logic [W-1:0] eData;
        logic [2:0]   eCnt;
        logic         eAf;
    } vec_t;

    vec_t vecs[$];
    logic [W-1:0] sb[$];

    function automatic vec_t mk(input logic aV, input logic [W-1:0] aD, input logic bR, input logic fl,
                                input logic eRdy, input logic eVal, input logic [W-1:0] eData,
                                input logic [2:0] eCnt, input logic eAf);
        return '{aV, aD, bR, fl, eRdy, eVal, eData, eCnt, eAf};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    initial begin
        // A->B lane cycle table; expectations are sampled while that row's inputs are still driven.
        vecs.push_back(mk(1'b0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00, 3'd0, 1'b0));
        vecs.push_back(mk(1'b1, 16'h11, 1'b0, 1'b0, 1'b1, 1'b1, 16'h11, 3'd1, 1'b0));
        vecs.push_back(mk(1'b1, 16'h22, 1'b0, 1'b0, 1'b1, 1'b1, 16'h11, 3'd2, 1'b0));
        vecs.push_back(mk(1'b1, 16'h33, 1'b0, 1'b0, 1'b1, 1'b1, 16'h11, 3'd3, 1'b1));
        vecs.push_back(mk(1'b1, 16'h44, 1'b0, 1'b0, 1'b0, 1'b1, 16'h11, 3'd4, 1'b1));
        vecs.push_back(mk(1'b1, 16'h55, 1'b0, 1'b0, 1'b0, 1'b1, 16'h11, 3'd4, 1'b1));
        vecs.push_back(mk(1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 1'b1, 16'h22, 3'd3, 1'b1));
        vecs.push_back(mk(1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 1'b1, 16'h33, 3'd2, 1'b0));
        vecs.push_back(mk(1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 1'b1, 16'h44, 3'd1, 1'b0));
        vecs.push_back(mk(1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00, 3'd0, 1'b0));
        vecs.push_back(mk(1'b1, 16'hA5, 1'b1, 1'b0, 1'b1, 1'b1, 16'hA5, 3'd1, 1'b0));
        vecs.push_back(mk(1'b0, 16'h00, 1'b1, 1'b0, 1'b1, 1'b0, 16'h00, 3'd0, 1'b0));
        vecs.push_back(mk(1'b1, 16'h01, 1'b0, 1'b0, 1'b1, 1'b1, 16'h01, 3'd1, 1'b0));
        vecs.push_back(mk(1'b1, 16'h02, 1'b0, 1'b0, 1'b1, 1'b1, 16'h01, 3'd2, 1'b0));
        vecs.push_back(mk(1'b1, 16'h03, 1'b0, 1'b0, 1'b1, 1'b1, 16'h01, 3'd3, 1'b1));
        vecs.push_back(mk(1'b1, 16'h04, 1'b0, 1'b0, 1'b0, 1'b1, 16'h01, 3'd4, 1'b1));
        vecs.push_back(mk(1'b1, 16'h05, 1'b1, 1'b0, 1'b1, 1'b1, 16'h02, 3'd3, 1'b1));
        vecs.push_back(mk(1'b0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b1, 16'h02, 3'd3, 1'b1));
        vecs.push_back(mk(1'b1, 16'h99, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00, 3'd0, 1'b0));
        vecs.push_back(mk(1'b0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00, 3'd0, 1'b0));
        vecs.push_back(mk(1'b1, 16'h66, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00, 3'd0, 1'b0));
        vecs.push_back(mk(1'b1, 16'h66, 1'b0, 1'b1, 1'b0, 1'b0, 16'h00, 3'd0, 1'b0));
        vecs.push_back(mk(1'b0, 16'h00, 1'b0, 1'b0, 1'b1, 1'b0, 16'h00, 3'd0, 1'b0));

        step;
        step;
        chk("rst aOutReady", 32'(aOutReady), 32'd0);
        chk("rst bOutValid", 32'(bOutValid), 32'd0);
        chk("rst abCount", 32'(abCount), 32'd0);
        chk("rst abAlmostFull", 32'(abAlmostFull), 32'd0);
        chk("rst bOutReady", 32'(bOutReady), 32'd0);
        chk("rst aOutValid", 32'(aOutValid), 32'd0);
        chk("rst baCount", 32'(baCount), 32'd0);
        chk("rst baAlmostFull", 32'(baAlmostFull), 32'd0);
        reset = 1'b1;

        foreach (vecs[i]) begin
            aInValid = vecs[i].aV;
            aInData  = vecs[i].aD;
            bInReady = vecs[i].bR;
            abFlush  = vecs[i].fl;
            step;
            chk($sformatf("vec%0d aOutReady", i), 32'(aOutReady), 32'(vecs[i].eRdy));
            chk($sformatf("vec%0d bOutValid", i), 32'(bOutValid), 32'(vecs[i].eVal));
            chk($sformatf("vec%0d abCount", i), 32'(abCount), 32'(vecs[i].eCnt));
            chk($sformatf("vec%0d abAlmostFull", i), 32'(abAlmostFull), 32'(vecs[i].eAf));
            if (vecs[i].eVal) chk($sformatf("vec%0d bOutData", i), 32'(bOutData), 32'(vecs[i].eData));
        end
        aInValid = 1'b0;
        abFlush  = 1'b0;
        bInReady = 1'b0;

        // Flushing A->B must leave B->A contents untouched.
        bInValid = 1'b1;
        bInData  = 16'hBEEF;
        step;
        bInData  = 16'hCAFE;
        step;
        bInValid = 1'b0;
        aInValid = 1'b1;
        aInData  = 16'h0012;
        step;
        chk("iso abCount pre", 32'(abCount), 32'd1);
        abFlush = 1'b1;
        aInData = 16'h0013;
        step;
        chk("iso abCount", 32'(abCount), 32'd0);
        chk("iso bOutValid", 32'(bOutValid), 32'd0);
        chk("iso aOutReady flush", 32'(aOutReady), 32'd0);
        chk("iso baCount", 32'(baCount), 32'd2);
        chk("iso baAlmostFull", 32'(baAlmostFull), 32'd1);
        chk("iso aOutValid", 32'(aOutValid), 32'd1);
        chk("iso aOutData", 32'(aOutData), 32'hBEEF);
        abFlush  = 1'b0;
        aInValid = 1'b0;
        step;
        chk("iso aOutReady after", 32'(aOutReady), 32'd1);
        chk("iso abCount after", 32'(abCount), 32'd0);
        baFlush = 1'b1;
        step;
        baFlush = 1'b0;
        step;
        chk("baFlush baCount", 32'(baCount), 32'd0);
        chk("baFlush aOutValid", 32'(aOutValid), 32'd0);
        chk("baFlush bOutReady", 32'(bOutReady), 32'd1);

        // B->A streaming across pointer wraps of the depth-3 lane.
        begin
            int sent = 0;
            int got = 0;
            int cyc = 0;
            aInReady = 1'b1;
            while (got < 1000 && cyc < 5000) begin
                bInValid = (sent < 1000) && ($urandom_range(3) != 0);
                bInData  = W'($urandom);
                if (aOutValid) begin
                    if (sb.size() == 0) chk("stream underflow", 32'(aOutData), 32'hFFFF_FFFF);
                    else chk("stream aOutData", 32'(aOutData), 32'(sb.pop_front()));
                    got++;
                end
                if (bInValid && bOutReady) begin
                    sb.push_back(bInData);
                    sent++;
                end
                chk("stream baCount<=1", 32'(baCount <= 3'd1), 32'd1);
                step;
                cyc++;
            end
            chk("stream beats received", 32'(got), 32'd1000);
            bInValid = 1'b0;
            aInReady = 1'b0;
        end

        // Asynchronous reset in the middle of a burst.
        aInValid = 1'b1;
        aInData  = 16'h0031;
        step;
        aInData  = 16'h0032;
        step;
        aInValid = 1'b0;
        chk("burst abCount", 32'(abCount), 32'd2);
        #2 reset = 1'b0;
        #1;
        chk("arst aOutReady", 32'(aOutReady), 32'd0);
        chk("arst bOutValid", 32'(bOutValid), 32'd0);
        chk("arst abCount", 32'(abCount), 32'd0);
        chk("arst abAlmostFull", 32'(abAlmostFull), 32'd0);
        chk("arst bOutReady", 32'(bOutReady), 32'd0);
        chk("arst aOutValid", 32'(aOutValid), 32'd0);
`ifdef OC_BC_BIDI_FIFO_STATS_EN
        chk("arst abBeats", abBeats, 32'd0);
        chk("arst baBeats", baBeats, 32'd0);
        chk("arst abStalls", abStalls, 32'd0);
        chk("arst baStalls", baStalls, 32'd0);
`endif
        @(negedge clock);
        reset = 1'b1;
        step;
        chk("post aOutReady", 32'(aOutReady), 32'd1);
        chk("post bOutValid", 32'(bOutValid), 32'd0);
        aInValid = 1'b1;
        aInData  = 16'h0077;
        step;
        aInValid = 1'b0;
        chk("post bOutValid1", 32'(bOutValid), 32'd1);
        chk("post bOutData", 32'(bOutData), 32'h0077);
        chk("post abCount", 32'(abCount), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule

// File: doc/oclib_bc_bidi_fifo_adapter.md
Name: oclib_bc_bidi_fifo_adapter

Overview:
- Parametrised bidirectional ready/valid byte-channel (BC) buffer between endpoint A and endpoint B.
- Each direction has its own first-word-fall-through FIFO. Data width and the two depths are set independently.
- Each direction has a synchronous flush, an occupancy output and an almost-full flag.
- Placed between BC producers and consumers where timing isolation or burst absorption beyond a pipeline stage is needed.

Parameters:
- Width, 8, data bits per beat in both directions.
- DepthAB, 4, entries in the A->B FIFO; legal values 2..256.
- DepthBA, 4, entries in the B->A FIFO; legal values 2..256.
- AlmostFullAB, DepthAB-1, A->B occupancy at which abAlmostFull asserts.
- AlmostFullBA, DepthBA-1, B->A occupancy at which baAlmostFull asserts.
- CountWidth, $clog2(max(DepthAB,DepthBA)+1), width of the occupancy outputs.

Ports:
- clock  input  1  single clock for all logic.
- reset  input  1  asynchronous, active-low reset (asserted when 0).
- aInData  input  Width  A->B data.
- aInValid  input  1  A->B valid.
- aOutReady  output  1  A->B FIFO can accept a beat.
- bOutData  output  Width  A->B data toward B.
- bOutValid  output  1  A->B data valid toward B.
- bInReady  input  1  B accepts a beat.
- bInData  input  Width  B->A data.
- bInValid  input  1  B->A valid.
- bOutReady  output  1  B->A FIFO can accept a beat.
- aOutData  output  Width  B->A data toward A.
- aOutValid  output  1  B->A data valid toward A.
- aInReady  input  1  A accepts a beat.
- abFlush  input  1  synchronous flush of the A->B FIFO.
- baFlush  input  1  synchronous flush of the B->A FIFO.
- abCount  output  CountWidth  A->B occupancy.
- baCount  output  CountWidth  B->A occupancy.
- abAlmostFull  output  1  abCount >= AlmostFullAB.
- baAlmostFull  output  1  baCount >= AlmostFullBA.

Behaviour:
- The two directions are identical and fully independent; rules below apply to each lane (in/out/flush/count).
- Reset (reset=0, asynchronous):
  - Pointers and counts cleared to 0.
  - outValid=0, inReady=0, almostFull=0.
  - Storage contents are not reset.
  - Reset asserted mid-transfer discards all in-flight beats.
- First cycle after reset deasserts: inReady=1.
- Push when inValid & inReady. Pop when outValid & outReady.
- inReady is registered and equals (count < Depth).
  - No pass-through on full: a pop while full raises inReady one cycle later.
  - inReady does not depend combinationally on outReady.
- outValid is registered and equals (count != 0).
  - A beat pushed into an empty FIFO appears on out the next cycle (latency 1).
  - outData is the head entry and is held stable while outValid & !outReady.
- Simultaneous push and pop:
  - Count unchanged.
  - When count==1, the new beat becomes head on the following cycle with no bubble.
- Pointers are binary and wrap from Depth-1 to 0. Non-power-of-2 depths are supported.
- count updates as +1 on push only, -1 on pop only, else unchanged. It never exceeds Depth and never underflows.
- almostFull is registered from the next-state count.
- Flush (synchronous):
  - In the cycle flush=1: inReady is forced 0 (no push), a pop still completes if outReady.
  - Next cycle: count=0, outValid=0, inReady=1, pointers equal.
  - Flush held for multiple cycles keeps the lane empty with inReady=0.
- Unknown parameter combinations (Depth<2, AlmostFull>Depth) fail elaboration via OC_STATIC_ERROR.

Optional Feature:
- Macro OC_BC_BIDI_FIFO_STATS_EN.
- When defined:
  - Adds outputs abBeats[31:0], baBeats[31:0], abStalls[31:0], baStalls[31:0].
  - Beats count pops. Stalls count cycles with outValid & !outReady.
  - All saturate at 32'hFFFFFFFF, reset to 0, and are cleared by the lane flush.
- When undefined: these ports and counters do not exist; behaviour is otherwise identical.

Decomposition:
- oclib_pkg gains bc_fifo_status_s (count, almostFull) and a constant BcFifoMaxDepth=256.
- One sub-module: oclib_bc_fifo_lane (single direction: FIFO, count, flush, optional stats), instantiated twice.

Test Plan:
- Width=8, DepthAB=4: push 0x11,0x22,0x33,0x44 with bInReady=0 -> abCount=4, aOutReady=0 the next cycle, abAlmostFull=1 at count 3. Release bInReady -> bytes emerge in order with no bubbles.
- Empty FIFO, single push of 0xA5 at cycle N -> bOutValid=1 with 0xA5 at N+1. With bInReady=1, count returns to 0 at N+2.
- Streaming with both ready high, Width=16, DepthBA=3 (non-power-of-2), 1000 random beats -> output order matches a scoreboard across pointer wraps, and baCount stays at or below 1.
- FIFO full with pop and push in the same cycle -> push refused (aOutReady=0 that cycle), count becomes 3, aOutReady=1 the following cycle.
- Load 3 beats, pulse abFlush for one cycle while aInValid=1 -> that beat is dropped, abCount=0 and bOutValid=0 the next cycle. The B->A lane is unaffected.
- Drive reset=0 asynchronously mid-burst -> all outputs go to reset values immediately; after release, the first new beat passes with latency 1. With the stats macro defined, counters read 0.
